seqdet_step_controller: RTL
===========================

Name: seqdet_step_controller

Overview:
- Sequences the bit-serial "1001" sequence detector on the board.
- Latches a test pattern, presents it to the detector's x input one bit per step, and issues a single-cycle advance strobe per step.
- Samples the detector's y output after each step and counts detections; step rate is either a prescaled tick or a manual step button.
- Sits between the board I/O (buttons, 7-segment/LEDs) and the detector, replacing the detector-local delay counter as the single step-timing source.

Parameters:
- DIV, 20000000, clk cycles per automatic step (valid range ≥2).
- PAT_W, 16, pattern register width in bits.
- CNT_W, 4, hit counter width.

Ports:
- clk  input  1  system clock (Sys_Clk0 domain).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE only, launches a run.
- abort  input  1  level; returns to IDLE from any state without asserting done.
- pat_in  input  PAT_W  pattern, sent MSB-first (bit len-1 down to bit 0 of the low len bits).
- len_in  input  $clog2(PAT_W)+1  number of bits to send; 0 or >PAT_W is treated as PAT_W.
- step_mode  input  1  0 = prescaler-driven steps; 1 = manual steps via step_btn.
- step_btn  input  1  synchronous, already debounced; a 0→1 edge requests one step.
- det_y  input  1  detector output, active-low hit.
- det_x  output  1  current pattern bit to the detector.
- det_en  output  1  one-cycle advance strobe to the detector.
- busy  output  1  high from the cycle after start until the run ends.
- done  output  1  one-cycle pulse at the end of a completed run.
- hit_cnt  output  CNT_W  detections counted in the current/last run; saturates at all-ones.
- bit_idx  output  $clog2(PAT_W)+1  bits already stepped in the current run.

Behaviour:
- Reset values:
  - All outputs 0 (det_x=0, det_en=0, busy=0, done=0, hit_cnt=0, bit_idx=0).
  - Prescaler 0, step_btn edge register 0, state IDLE.
- IDLE:
  - start=1 → latch pattern and effective length (len_in clamped as above).
  - Clear hit_cnt, bit_idx and prescaler; go to SHIFT. busy=1 from the next cycle.
- SHIFT:
  - det_x = pattern[len-1-bit_idx], held stable for the whole state.
  - Step request when step_mode=0: prescaler reaches DIV-1, then prescaler wraps to 0.
  - Step request when step_mode=1: step_btn rising edge; the prescaler is held at 0.
  - On a step request, det_en=1 for exactly that one cycle; next state SAMPLE.
- SAMPLE (1 cycle; det_en=0, det_x unchanged):
  - If det_y==0, hit_cnt += 1, saturating at 2^CNT_W-1.
  - bit_idx += 1.
  - If the new bit_idx == len → DONE, else → SHIFT.
- DONE (1 cycle): done=1, busy=0 in the same cycle; next state IDLE. hit_cnt and bit_idx hold until the next start.
- Step timing: exactly one det_en per pattern bit. In auto mode consecutive det_en are spaced DIV cycles apart; the SAMPLE cycle is counted inside the prescaler, which keeps running through SAMPLE.
- Mode switch: step_mode is sampled per cycle. Switching mid-run changes the step source from the next cycle; the prescaler clears when entering manual mode.
- Priority: abort > step. abort=1 in any state → IDLE next cycle with busy=0, done=0, det_en=0; hit_cnt and bit_idx are frozen.
- start while busy is ignored. start held high in IDLE after DONE starts a new run (start is level-sensitive).
- Reset asserted mid-run clears asynchronously to the reset values; no det_en is emitted while rst_n=0.

Test Plan:
- DIV=4, auto mode, pat_in=16'h0009, len_in=4, detector model attached → det_x sequence 1,0,0,1; det_en every 4 cycles; done pulse; hit_cnt=1; bit_idx=4.
- DIV=4, pat_in=16'h0099, len_in=8 (10011001) → hit_cnt=2; exactly 8 det_en pulses; busy low in the same cycle done is high.
- step_mode=1, pat_in=16'h0009, len_in=4; three step_btn edges, then wait 100 cycles → bit_idx=3, busy=1, no done; 4th edge → done, hit_cnt=1. A held step_btn gives exactly one step.
- det_y forced to 0, len_in=0 with CNT_W=4 → 16 steps; hit_cnt saturates at 15.
- abort asserted after the 2nd det_en → IDLE next cycle; no done; hit_cnt/bit_idx frozen at 0/2; new start reruns from bit 0.
- rst_n pulsed low mid-SHIFT (asynchronously, between clock edges) → all outputs 0 immediately; no det_en until a new start.

Source files
------------

// File: rtl/seqdet_step_if.sv
// Board-side bundle between the step controller and its neighbours:
// run control and pattern in, detector drive and status out.
interface seqdet_step_if #(
    parameter int PAT_W = 16,
    parameter int CNT_W = 4
);
    localparam int LW = $clog2(PAT_W) + 1;

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [LW-1:0]    len_in;
    logic             step_mode;
    logic             step_btn;
    logic             det_y;
    logic             det_x;
    logic             det_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
    logic [LW-1:0]    bit_idx;

    // Board side: drives run control and pattern, watches status
    modport master (
        output start, abort, pat_in, len_in, step_mode, step_btn, det_y,
        input  det_x, det_en, busy, done, hit_cnt, bit_idx
    );

    // Controller side
    modport slave (
        input  start, abort, pat_in, len_in, step_mode, step_btn, det_y,
        output det_x, det_en, busy, done, hit_cnt, bit_idx
    );
endinterface

// File: rtl/seqdet_step_controller.sv
// Step sequencer for the bit-serial "1001" detector: latches a pattern,
// feeds it MSB-first one bit per step, strobes the detector once per step
// and counts the active-low hits it reports back.
module seqdet_step_controller #(
    parameter int DIV   = 20000000,
    parameter int PAT_W = 16,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seqdet_step_if.slave  bus
);
    localparam int LW = $clog2(PAT_W) + 1;
    localparam int PW = $clog2(DIV);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_reg,   state_next;
    logic [PAT_W-1:0] pat_reg,     pat_next;
    logic [LW-1:0]    len_reg,     len_next;
    logic [LW-1:0]    bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
    logic [PW-1:0]    presc_reg,   presc_next;
    logic             btn_q_reg;

    logic [LW-1:0]    len_eff;
    logic [LW-1:0]    bit_sel;
    logic [LW-1:0]    bit_idx_inc;
    logic             btn_edge;
    logic             presc_wrap;
    logic             step_req;
    logic             in_run;

    // Zero or oversize lengths mean "send the whole register"
    assign len_eff = (bus.len_in == '0 || bus.len_in > LW'(PAT_W)) ? LW'(PAT_W) : bus.len_in;

    // Bits go out MSB-first within the low len bits
    assign bit_sel     = len_reg - bit_idx_reg - LW'(1);
    assign bit_idx_inc = bit_idx_reg + LW'(1);

    assign btn_edge   = bus.step_btn & ~btn_q_reg;
    assign presc_wrap = (presc_reg == PW'(DIV - 1));
    assign step_req   = bus.step_mode ? btn_edge : presc_wrap;
    assign in_run     = (state_reg == SHIFT) || (state_reg == SAMPLE);

    // Outputs decoded from state; abort masks the strobe and the done pulse
    assign bus.det_x   = in_run & |(pat_reg & (PAT_W'(1) << bit_sel));
    assign bus.det_en  = (state_reg == SHIFT) & step_req & ~bus.abort;
    assign bus.busy    = in_run;
    assign bus.done    = (state_reg == DONE) & ~bus.abort;
    assign bus.hit_cnt = hit_cnt_reg;
    assign bus.bit_idx = bit_idx_reg;

    // Next-state and datapath update; abort overrides everything
    always_comb begin
        state_next   = state_reg;
        pat_next     = pat_reg;
        len_next     = len_reg;
        bit_idx_next = bit_idx_reg;
        hit_cnt_next = hit_cnt_reg;
        presc_next   = '0;

        // Prescaler only runs while a run is active in auto mode; it keeps
        // counting through SAMPLE so auto steps stay exactly DIV apart
        if (in_run && !bus.step_mode) begin
            presc_next = presc_wrap ? '0 : presc_reg + PW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    pat_next     = bus.pat_in;
                    len_next     = len_eff;
                    bit_idx_next = '0;
                    hit_cnt_next = '0;
                    presc_next   = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (step_req) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!bus.det_y && hit_cnt_reg != '1) begin
                    hit_cnt_next = hit_cnt_reg + CNT_W'(1);
                end
                bit_idx_next = bit_idx_inc;
                state_next   = (bit_idx_inc == len_reg) ? DONE : SHIFT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_next   = IDLE;
            bit_idx_next = bit_idx_reg;
            hit_cnt_next = hit_cnt_reg;
            presc_next   = '0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            len_reg     <= '0;
            bit_idx_reg <= '0;
            hit_cnt_reg <= '0;
            presc_reg   <= '0;
            btn_q_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pat_reg     <= pat_next;
            len_reg     <= len_next;
            bit_idx_reg <= bit_idx_next;
            hit_cnt_reg <= hit_cnt_next;
            presc_reg   <= presc_next;
            btn_q_reg   <= bus.step_btn;
        end
    end
endmodule
